// File: rtl/karaoke_mix_sched_if.sv
// Bus bundle for the karaoke mixer: HPS volume/play PIOs, music/mic
// Avalon-ST sinks, DAC Avalon-ST source and status.
interface karaoke_mix_sched_if #(
    parameter int unsigned VOL_W = 7,
    parameter int unsigned CNT_W = 16
) ();
    logic             sample_tick;
    logic             play;
    logic [VOL_W-1:0] vol_ctrl;
    logic             vol_flag;
    logic             vol_ack;
    logic             wav_valid;
    logic [31:0]      wav_data;
    logic             wav_ready;
    logic             mic_valid;
    logic [31:0]      mic_data;
    logic             mic_ready;
    logic             dac_valid;
    logic [31:0]      dac_data;
    logic             dac_ready;
    logic [CNT_W-1:0] underrun_cnt;
    logic             overrun;

    modport slave (
        input  sample_tick, play, vol_ctrl, vol_flag,
        input  wav_valid, wav_data, mic_valid, mic_data, dac_ready,
        output vol_ack, wav_ready, mic_ready, dac_valid, dac_data,
        output underrun_cnt, overrun
    );

    modport master (
        output sample_tick, play, vol_ctrl, vol_flag,
        output wav_valid, wav_data, mic_valid, mic_data, dac_ready,
        input  vol_ack, wav_ready, mic_ready, dac_valid, dac_data,
        input  underrun_cnt, overrun
    );
endinterface

// File: rtl/karaoke_mix_sched.sv
// Per-sample playback scheduler: on each codec tick fetch music + mic,
// scale music by the HPS volume, saturate-mix and hand the word to the DAC.
module karaoke_mix_sched #(
    parameter int unsigned VOL_W     = 7,
    parameter int unsigned VOL_RESET = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    karaoke_mix_sched_if.slave   io_mix
);

    localparam int unsigned PW = 16 + VOL_W + 1;
    localparam int unsigned SW = PW - 5;

    localparam logic [1:0] ST_WAIT_TICK = 2'd0;
    localparam logic [1:0] ST_FETCH     = 2'd1;
    localparam logic [1:0] ST_MIX       = 2'd2;
    localparam logic [1:0] ST_EMIT      = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_pending;
    logic             r_vol_ack;
    logic             r_dac_valid;
    logic             r_overrun;
    logic [VOL_W-1:0] r_vol;
    logic [31:0]      r_music;
    logic [31:0]      r_mic;
    logic [31:0]      r_dac_data;
    logic [CNT_W-1:0] r_underrun;
    logic             w_wait;
    logic             w_fetch;
    logic             w_go;
    logic             w_wav_xfer;
    logic             w_mic_xfer;
    logic [31:0]      w_mix;

    // One channel: (music * vol) / 64 with arithmetic shift, add mic, clamp to int16.
    function automatic logic [15:0] mix_ch(input logic [15:0] m,
                                           input logic [15:0] k,
                                           input logic [VOL_W-1:0] v);
        logic signed [PW-1:0] p;
        logic signed [SW-1:0] s;
        p = PW'($signed(m)) * PW'($signed({1'b0, v}));
        s = SW'(p >>> 6) + SW'($signed(k));
        if (s > SW'(32'sd32767))
            mix_ch = 16'h7FFF;
        else if (s < SW'(-32'sd32768))
            mix_ch = 16'h8000;
        else
            mix_ch = s[15:0];
    endfunction

    assign w_wait     = (r_state == ST_WAIT_TICK);
    assign w_fetch    = (r_state == ST_FETCH);
    assign w_go       = w_wait & (io_mix.sample_tick | r_pending);
    assign w_wav_xfer = w_fetch & io_mix.play & io_mix.wav_valid;
    assign w_mic_xfer = w_fetch & io_mix.mic_valid;
    assign w_mix      = {mix_ch(r_music[31:16], r_mic[31:16], r_vol),
                         mix_ch(r_music[15:0],  r_mic[15:0],  r_vol)};

    assign io_mix.wav_ready    = w_fetch & io_mix.play;
    assign io_mix.mic_ready    = w_fetch;
    assign io_mix.vol_ack      = r_vol_ack;
    assign io_mix.dac_valid    = r_dac_valid;
    assign io_mix.dac_data     = r_dac_data;
    assign io_mix.underrun_cnt = r_underrun;
    assign io_mix.overrun      = r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_WAIT_TICK;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_TICK: if (w_go) w_state_nxt = ST_FETCH;
            ST_FETCH:     w_state_nxt = ST_MIX;
            ST_MIX:       w_state_nxt = ST_EMIT;
            ST_EMIT:      if (io_mix.dac_ready) w_state_nxt = ST_WAIT_TICK;
            default:      w_state_nxt = ST_WAIT_TICK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending   <= 1'b0;
            r_vol_ack   <= 1'b0;
            r_vol       <= VOL_W'(VOL_RESET);
            r_overrun   <= 1'b0;
            r_underrun  <= '0;
            r_music     <= '0;
            r_mic       <= '0;
            r_dac_data  <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            // Volume only changes between samples so a sample never sees a half-update.
            if (!io_mix.vol_flag) begin
                r_vol_ack <= 1'b0;
            end else if (w_wait && !r_vol_ack) begin
                r_vol     <= io_mix.vol_ctrl;
                r_vol_ack <= 1'b1;
            end

            // One tick may be parked while busy; a second one is lost.
            if (w_wait) begin
                r_pending <= 1'b0;
            end else if (io_mix.sample_tick) begin
                if (r_pending)
                    r_overrun <= 1'b1;
                else
                    r_pending <= 1'b1;
            end

            if (w_fetch) begin
                r_music <= w_wav_xfer ? io_mix.wav_data : 32'h0;
                r_mic   <= w_mic_xfer ? io_mix.mic_data : 32'h0;
                if (io_mix.play && !io_mix.wav_valid && (r_underrun != '1))
                    r_underrun <= r_underrun + CNT_W'(1);
            end

            if (r_state == ST_MIX) begin
                r_dac_data  <= w_mix;
                r_dac_valid <= 1'b1;
            end else if ((r_state == ST_EMIT) && io_mix.dac_ready) begin
                r_dac_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_karaoke_mix_sched.sv
// Directed bench for karaoke_mix_sched: scoreboard of expected DAC words
// from an arithmetic mixing model, plus hand-computed literal checks.
module tb_karaoke_mix_sched;

    logic clk;
    logic reset;

    karaoke_mix_sched_if #(.VOL_W(7), .CNT_W(16)) bus ();

    karaoke_mix_sched #(.VOL_W(7), .VOL_RESET(64), .CNT_W(16)) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .io_mix (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          model_vol = 64;
    int          model_underrun = 0;
    int          model_overrun = 0;
    int          n_wav_rdy = 0;
    int          n_mic_rdy = 0;
    int          n_xfer = 0;
    logic [31:0] last_dac = '0;
    logic [31:0] exp_q[$];
    logic        hold_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division by 64, then clamp to int16.
    function automatic int chan(input int mus, input int mic, input int vol);
        int p;
        int s;
        p = mus * vol;
        if (p < 0) s = -((-p + 63) / 64);
        else       s = p / 64;
        s = s + mic;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic logic [31:0] model_mix(input logic [31:0] w, input logic [31:0] m, input int vol);
        logic signed [15:0] wl, wr, ml, mr;
        int l, r;
        wl = w[31:16]; wr = w[15:0]; ml = m[31:16]; mr = m[15:0];
        l = chan(int'(wl), int'(ml), vol);
        r = chan(int'(wr), int'(mr), vol);
        return {l[15:0], r[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
    endtask

    task automatic launch(input logic [31:0] w, input logic wv, input logic [31:0] m,
                          input logic mv, input logic pl);
        bus.wav_data  = w;
        bus.wav_valid = wv;
        bus.mic_data  = m;
        bus.mic_valid = mv;
        bus.play      = pl;
        exp_q.push_back(model_mix((pl && wv) ? w : 32'h0, mv ? m : 32'h0, model_vol));
        if (pl && !wv) model_underrun++;
        pulse_tick();
    endtask

    task automatic set_vol(input int v);
        bus.vol_ctrl = 7'(v);
        bus.vol_flag = 1'b1;
        for (int i = 0; i < 20 && !bus.vol_ack; i++) step();
        check("vol_ack_rise", 32'(bus.vol_ack), 32'd1);
        model_vol = v;
        bus.vol_flag = 1'b0;
        step();
        @(negedge clk);
        check("vol_ack_fall", 32'(bus.vol_ack), 32'd0);
    endtask

    // Unity sample with latency pinned to tick+3.
    task automatic unity_sample(input string tag);
        bus.dac_ready = 1'b1;
        n_wav_rdy = 0;
        n_mic_rdy = 0;
        launch(32'h1000_F000, 1'b1, 32'h0010_0010, 1'b1, 1'b1);
        @(negedge clk);
        check({tag, "_fetch_wav_ready"}, 32'(bus.wav_ready), 32'd1);
        check({tag, "_fetch_dac_valid"}, 32'(bus.dac_valid), 32'd0);
        @(negedge clk);
        check({tag, "_mix_dac_valid"}, 32'(bus.dac_valid), 32'd0);
        @(negedge clk);
        check({tag, "_emit_dac_valid"}, 32'(bus.dac_valid), 32'd1);
        check({tag, "_emit_dac_data"}, bus.dac_data, 32'h1010_F010);
        repeat (4) step();
        check({tag, "_wav_ready_cycles"}, 32'(n_wav_rdy), 32'd1);
        check({tag, "_mic_ready_cycles"}, 32'(n_mic_rdy), 32'd1);
    endtask

    always @(negedge clk) begin
        if (bus.wav_ready) n_wav_rdy++;
        if (bus.mic_ready) n_mic_rdy++;
    end

    // Scoreboard compare on every DAC cycle.
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                check("dac_hold_valid", 32'(bus.dac_valid), 32'd1);
            if (bus.dac_valid && bus.dac_ready) begin
                n_xfer++;
                last_dac = bus.dac_data;
                if (exp_q.size() == 0) begin
                    check("dac_unexpected_word", bus.dac_data, 32'hxxxx_xxxx);
                end else begin
                    check("dac_data", bus.dac_data, exp_q.pop_front());
                    check("underrun_cnt", 32'(bus.underrun_cnt), 32'(model_underrun));
                    check("overrun", 32'(bus.overrun), 32'(model_overrun));
                end
            end
            hold_prev = bus.dac_valid && !bus.dac_ready;
        end
    end

    initial begin
        int xfer0;
        reset           = 1'b1;
        bus.sample_tick = 1'b0;
        bus.play        = 1'b0;
        bus.vol_ctrl    = '0;
        bus.vol_flag    = 1'b0;
        bus.wav_valid   = 1'b0;
        bus.wav_data    = '0;
        bus.mic_valid   = 1'b0;
        bus.mic_data    = '0;
        bus.dac_ready   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_dac_valid", 32'(bus.dac_valid), 32'd0);
        check("rst_dac_data", bus.dac_data, 32'h0);
        check("rst_wav_ready", 32'(bus.wav_ready), 32'd0);
        check("rst_mic_ready", 32'(bus.mic_ready), 32'd0);
        check("rst_vol_ack", 32'(bus.vol_ack), 32'd0);
        check("rst_underrun", 32'(bus.underrun_cnt), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        step();

        unity_sample("s1");

        set_vol(127);
        launch(32'h7000_9000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        repeat (6) step();
        check("s2_saturate", last_dac, 32'h7FFF_8000);

        set_vol(64);
        launch(32'h0000_0000, 1'b0, 32'h0123_0456, 1'b1, 1'b1);
        repeat (6) step();
        check("s3_underrun_data", last_dac, 32'h0123_0456);
        check("s3_underrun_cnt", 32'(bus.underrun_cnt), 32'd1);
        n_wav_rdy = 0;
        launch(32'h7FFF_7FFF, 1'b1, 32'h0123_0456, 1'b1, 1'b0);
        repeat (6) step();
        check("s3_pause_data", last_dac, 32'h0123_0456);
        check("s3_pause_wav_ready", 32'(n_wav_rdy), 32'd0);
        check("s3_pause_underrun", 32'(bus.underrun_cnt), 32'd1);

        bus.dac_ready = 1'b0;
        launch(32'h0040_0040, 1'b1, 32'h0, 1'b1, 1'b1);
        repeat (4) step();
        bus.vol_ctrl = 7'd32;
        bus.vol_flag = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("s4_ack_held_in_emit", 32'(bus.vol_ack), 32'd0);
        bus.dac_ready = 1'b1;
        for (int i = 0; i < 10 && !bus.vol_ack; i++) step();
        check("s4_ack_in_wait", 32'(bus.vol_ack), 32'd1);
        model_vol = 32;
        bus.vol_flag = 1'b0;
        step();
        @(negedge clk);
        check("s4_ack_drop", 32'(bus.vol_ack), 32'd0);
        launch(32'h2000_2000, 1'b1, 32'h0, 1'b1, 1'b1);
        repeat (6) step();
        check("s4_half_volume", last_dac, 32'h1000_1000);

        bus.dac_ready = 1'b0;
        xfer0 = n_xfer;
        launch(32'h0100_0100, 1'b1, 32'h0, 1'b1, 1'b1);
        repeat (3) step();
        check("s5_no_overrun_yet", 32'(bus.overrun), 32'd0);
        launch(32'h0100_0100, 1'b1, 32'h0, 1'b1, 1'b1);
        pulse_tick();
        model_overrun = 1;
        @(negedge clk);
        check("s5_overrun", 32'(bus.overrun), 32'd1);
        step();
        bus.dac_ready = 1'b1;
        repeat (12) step();
        check("s5_emitted_count", 32'(n_xfer - xfer0), 32'd2);
        check("s5_last_data", last_dac, 32'h0080_0080);

        bus.dac_ready = 1'b0;
        launch(32'h1111_2222, 1'b1, 32'h0, 1'b1, 1'b1);
        repeat (5) step();
        check("s6_holding", 32'(bus.dac_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        model_vol      = 64;
        model_underrun = 0;
        model_overrun  = 0;
        @(negedge clk);
        check("s6_dac_valid", 32'(bus.dac_valid), 32'd0);
        check("s6_underrun", 32'(bus.underrun_cnt), 32'd0);
        check("s6_overrun", 32'(bus.overrun), 32'd0);
        step();
        unity_sample("s6");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/karaoke_mix_sched.md
Name: karaoke_mix_sched

Overview:
- Per-sample playback scheduler between the HPS audio streams and the codec DAC stream.
- On each codec frame tick it:
  - pulls one music word from the HPS WAV stream and one mic word from the ADC stream;
  - applies the HPS-programmed volume to the music;
  - mixes with saturation and presents the result to the DAC stream.
- Owns the 4-phase volume-update handshake with the HPS PIOs, plus play/pause gating and underrun/overrun status.

Parameters:
- VOL_W, 7, volume register width; gain = vol/64 (64 = unity).
- VOL_RESET, 64, volume after reset.
- CNT_W, 16, width of saturating underrun counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- sample_tick  in  1  one-cycle pulse per codec frame (48 kHz).
- play  in  1  from play PIO; 1 = consume music, 0 = pause (music silent).
- vol_ctrl  in  VOL_W  new volume value from HPS PIO.
- vol_flag  in  1  HPS request: vol_ctrl is valid.
- vol_ack  out  1  to HPS read-back PIO: volume latched.
- wav_valid/wav_data[31:0]/wav_ready  in/in/out  music Avalon-ST sink, readyLatency 0; [31:16] L, [15:0] R, signed.
- mic_valid/mic_data[31:0]/mic_ready  in/in/out  mic Avalon-ST sink, same format.
- dac_valid/dac_data[31:0]/dac_ready  out/out/in  mixed Avalon-ST source.
- underrun_cnt  out  CNT_W  count of ticks with play=1 and no music word.
- overrun  out  1  sticky: a tick was dropped.

Behaviour:
Reset:
- state=WAIT_TICK, vol_reg=VOL_RESET, pending=0.
- All outputs 0: dac_valid, dac_data, wav_ready, mic_ready, vol_ack, underrun_cnt, overrun.

FSM:
- WAIT_TICK:
  - if sample_tick or pending → FETCH; clear pending.
  - Volume latch happens only here: if vol_flag=1 and vol_ack=0, vol_reg<=vol_ctrl and vol_ack<=1.
  - vol_ack<=0 the cycle after vol_flag is seen 0.
  - This makes volume changes atomic per sample.
- FETCH (exactly 1 cycle):
  - wav_ready=play, mic_ready=1; a transfer occurs where valid&ready.
  - music = wav_data if transferred, else 0.
  - If play=1 and wav_valid=0: underrun_cnt+1, saturating at all-ones.
  - mic = mic_data if transferred, else 0.
  - play is sampled in this cycle → MIX.
- MIX (1 cycle), per channel c, computed combinationally and registered into dac_data:
  - p = signed16(music_c) * unsigned(vol_reg), 23-bit signed.
  - s = (p >>> 6), 17-bit, + sext(mic_c) → 18-bit.
  - Saturate s to [-32768, 32767]; dac_valid<=1 → EMIT.
- EMIT:
  - Hold dac_valid and dac_data stable until dac_ready=1.
  - On the transfer cycle, dac_valid<=0 → WAIT_TICK.
- Latency: tick in cycle T → FETCH T+1, MIX T+2, dac_valid high T+3 (if dac_ready=1, back in WAIT_TICK T+4).

Tick outside WAIT_TICK:
- If pending=0, set pending.
- If pending=1, drop the tick and set overrun (sticky until reset).
- A tick in WAIT_TICK coincident with pending=1 counts once (no overrun).

Other rules:
- wav_ready/mic_ready are never high outside FETCH; no word is consumed without a tick.
- vol_flag raised outside WAIT_TICK waits; vol_ack stays 0 until the next WAIT_TICK.
- Reset asserted mid-EMIT: dac_valid=0 on the next cycle; any held sample is discarded.

Test Plan:
1. Unity: vol=64, play=1, wav=0x1000_F000, mic=0x0010_0010, dac_ready=1, tick → dac_valid at tick+3 with dac_data=0x1010_F010; wav_ready and mic_ready high one cycle only.
2. Saturation: vol=127, wav=0x7000_9000, mic=0x0000_0000 → dac_data=0x7FFF_8000.
3. Underrun/pause:
   - play=1, wav_valid=0, mic=0x0123_0456 → dac_data=0x0123_0456, underrun_cnt 0→1.
   - Repeat with play=0 → wav_ready never asserted, underrun_cnt unchanged.
4. Volume handshake:
   - vol_flag=1, vol_ctrl=32 raised during EMIT with dac_ready=0 → vol_ack stays 0.
   - Release dac_ready → vol_ack=1 in WAIT_TICK; drop vol_flag → vol_ack=0 next cycle.
   - Next sample wav=0x2000_2000, mic=0 → 0x1000_1000.
5. Backpressure: dac_ready=0, three ticks after the first sample → pending set by tick 2, overrun=1 on tick 3; release dac_ready → exactly one more sample is emitted.
6. Reset mid-EMIT (dac_ready=0): reset 1 cycle → dac_valid=0, vol_reg=64, underrun_cnt=0, overrun=0; next tick behaves as in scenario 1.
